// File: rtl/cla_tree_ctrl.sv
// Credit-based flow control around a fixed-latency adder tree, with an output FIFO that absorbs every in-flight result.
// Optional macro CLA_TREE_CTRL_SAT_EN: shift-and-saturate on push with sticky sat_flag; otherwise wrap with sat_flag tied low.
module cla_tree_ctrl #(
    parameter int WIDTH_IN   = 40,
    parameter int LAT        = 7,
    parameter int FIFO_DEPTH = 8,
    parameter int OUT_W      = 24,
    parameter int SHIFT      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       shift_en,
    input  logic signed [WIDTH_IN+6:0] tree_y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_W-1:0]    out_data,
    output logic                       busy,
    output logic                       sat_flag
);
    localparam int TW = WIDTH_IN + 7;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(LAT + 1);
    localparam int SW = $clog2(FIFO_DEPTH + LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LAT-1:0]   vld_q, vld_d;
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    inflight;
    logic [SW-1:0]    credits;
    logic             push, pop;
    logic [OUT_W-1:0] push_data;
    logic [OUT_W-1:0] mem [FIFO_DEPTH];

    // Every accepted sample holds a credit from acceptance until it leaves the FIFO,
    // so the FIFO can never overflow while results are in the tree.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + IW'(vld_q[i]);
        end
    end

    assign credits   = SW'(inflight) + SW'(cnt_q);
    assign in_ready  = (state_q == RUN) && (credits < SW'(FIFO_DEPTH));
    assign shift_en  = in_valid && in_ready;
    assign push      = vld_q[LAT-1];
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign busy      = (state_q != IDLE);
    assign out_data  = out_valid ? $signed(mem[rd_q]) : '0;

    assign vld_d[0] = shift_en;
    for (genvar gi = 1; gi < LAT; gi++) begin : g_vld
        assign vld_d[gi] = vld_q[gi-1];
    end

    assign wr_d  = push ? wr_q + PW'(1) : wr_q;
    assign rd_d  = pop  ? rd_q + PW'(1) : rd_q;
    assign cnt_d = cnt_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (flush || !en) state_d = DRAIN;
            DRAIN:   if ((inflight == '0) && (cnt_q == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vld_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage carries no reset; out_valid masks whatever it holds.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= push_data;
        end
    end

`ifdef CLA_TREE_CTRL_SAT_EN
    logic signed [TW-1:0]    shifted;
    logic [TW-OUT_W:0]       hi;
    logic                    clip;
    logic                    sat_q, sat_d;

    // In range only when every bit above the output sign bit copies it.
    assign shifted = tree_y >>> SHIFT;
    assign hi      = shifted[TW-1:OUT_W-1];
    assign clip    = !((&hi) || !(|hi));

    always_comb begin
        push_data = shifted[OUT_W-1:0];
        if (clip) begin
            push_data = shifted[TW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    assign sat_d = sat_q || (push && clip);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`else
    assign push_data = OUT_W'(tree_y >>> SHIFT);
    assign sat_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_cla_tree_ctrl.sv
// Directed bench for cla_tree_ctrl: models the 7-cycle adder tree and checks every delivered sample against a scoreboard queue.
module tb_cla_tree_ctrl;
    localparam int TW    = 47;
    localparam int OUT_W = 24;
    localparam int DEPTH = 8;

`ifdef CLA_TREE_CTRL_SAT_EN
    localparam logic [OUT_W-1:0] EXP_BIG = 24'h7FFFFF;
    localparam logic             EXP_SAT = 1'b1;
`else
    localparam logic [OUT_W-1:0] EXP_BIG = 24'h000000;
    localparam logic             EXP_SAT = 1'b0;
`endif

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic en        = 1'b0;
    logic flush     = 1'b0;
    logic in_valid  = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, shift_en, out_valid, busy, sat_flag;
    logic signed [TW-1:0]    tree_y;
    logic signed [OUT_W-1:0] out_data;

    logic signed [TW-1:0] cur_val = '0;
    logic signed [TW-1:0] tdl [7];
    logic                 se_cap  = 1'b0;
    logic signed [TW-1:0] val_cap = '0;
    logic [OUT_W-1:0]     sb [$];
    logic                 prev_stall = 1'b0;
    logic [OUT_W-1:0]     prev_data  = '0;
    int total = 0;
    int bad   = 0;
    int accepted;
    int n;

    cla_tree_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .shift_en  (shift_en),
        .tree_y    (tree_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    // Tree model: the value accepted in cycle t appears on tree_y during cycle t+7; junk otherwise.
    always @(posedge clk) begin
        for (int i = 6; i > 0; i--) tdl[i] <= tdl[i-1];
        tdl[0] <= se_cap ? val_cap : TW'({$urandom(), $urandom()});
    end
    assign tree_y = tdl[6];

    function automatic logic signed [TW-1:0] rnd();
        return TW'({$urandom(), $urandom()});
    endfunction

    function automatic logic [OUT_W-1:0] model(input logic signed [TW-1:0] v);
`ifdef CLA_TREE_CTRL_SAT_EN
        longint s;
        s = longint'(v) >>> 16;
        if (s > 64'sd8388607) return 24'h7FFFFF;
        if (s < -64'sd8388608) return 24'h800000;
        return s[23:0];
`else
        logic [TW-1:0] u;
        u = v;
        return u[39:16];
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [OUT_W-1:0] e;
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
            se_cap     = 1'b0;
            return;
        end
        if (prev_stall && out_valid) chk("hold", $unsigned(out_data), prev_data);
        if (out_valid && out_ready) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL pop_empty: observed=%0h expected=none", out_data);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("data", $unsigned(out_data), e);
            end
        end
        se_cap  = shift_en;
        val_cap = cur_val;
        if (shift_en) begin
            sb.push_back(model(cur_val));
            chk("credit", sb.size() <= DEPTH, 1);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    endtask

    task automatic mid();
        @(negedge clk);
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        mid();
        adv();
    endtask

    task automatic wait_empty(input string tag, input int budget);
        int k = 0;
        while ((sb.size() != 0 || out_valid) && k < budget) begin
            cyc();
            k++;
        end
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        // Reset with a pending source sample
        in_valid = 1'b1;
        repeat (3) cyc();
        mid();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_shift_en", shift_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", $unsigned(out_data), 0);
        chk("rst_sat", sat_flag, 0);
        adv();
        rst = 1'b0;
        in_valid = 1'b0;
        cyc();
        mid();
        chk("idle_in_ready", in_ready, 0);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_out_data", $unsigned(out_data), 0);
        chk("idle_sat", sat_flag, 0);
        adv();

        // Single sample latency
        en = 1'b1;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b1;
        cur_val = 47'sd5 <<< 16;
        mid();
        chk("lat_accept", shift_en, 1);
        adv();
        in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            mid();
            chk("lat_valid", out_valid, (k == 8));
            if (k == 8) chk("lat_data", $unsigned(out_data), 5);
            adv();
        end

        // Fill with sink stalled, then drain in order
        out_ready = 1'b0;
        in_valid = 1'b1;
        accepted = 0;
        for (int k = 0; k < 20; k++) begin
            cur_val = rnd();
            mid();
            if (shift_en) accepted++;
            adv();
        end
        mid();
        chk("fill_count", accepted, 8);
        chk("fill_ready", in_ready, 0);
        adv();
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_empty("fill_drain", 40);

        // Flush with three samples in flight
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cur_val = rnd();
            mid();
            chk("fl_accept", shift_en, 1);
            adv();
        end
        in_valid = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        mid();
        chk("fl_ready", in_ready, 0);
        chk("fl_busy", busy, 1);
        adv();
        n = 0;
        while (busy && n < 30) begin
            cyc();
            n++;
        end
        mid();
        chk("fl_idle", busy, 0);
        chk("fl_delivered", sb.size(), 0);
        adv();

        // Large value: saturates or wraps depending on build
        in_valid = 1'b1;
        cur_val = 47'sd1 <<< 45;
        mid();
        chk("big_accept", shift_en, 1);
        adv();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            cyc();
            n++;
        end
        mid();
        chk("big_data", $unsigned(out_data), EXP_BIG);
        adv();
        mid();
        chk("big_sat", sat_flag, EXP_SAT);
        adv();
        in_valid = 1'b1;
        cur_val = -(47'sd1 <<< 45);
        cyc();
        cur_val = -(47'sd3 <<< 16);
        cyc();
        cur_val = (47'sd12345 <<< 16) + 47'sd4660;
        cyc();
        in_valid = 1'b0;
        wait_empty("mix_drain", 40);

        // Reset with four samples buffered
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cur_val = rnd();
            mid();
            chk("buf_accept", shift_en, 1);
            adv();
        end
        in_valid = 1'b0;
        repeat (10) cyc();
        mid();
        chk("buf_valid", out_valid, 1);
        adv();
        rst = 1'b1;
        in_valid = 1'b1;
        mid();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_shift_en", shift_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_data", $unsigned(out_data), 0);
        chk("mid_rst_sat", sat_flag, 0);
        adv();
        in_valid = 1'b0;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            mid();
            chk("post_rst_valid", out_valid, 0);
            adv();
        end

        // Fresh sample after reset
        in_valid = 1'b1;
        cur_val = 47'sd7 <<< 16;
        mid();
        chk("post_rst_accept", shift_en, 1);
        adv();
        in_valid = 1'b0;
        wait_empty("post_rst_drain", 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
